// File: rtl/onchip_mem_loader_pkg.sv
// Shared definitions for the on-chip RAM loader.
//   state_t     : controller states
//   BYTES       : bytes per RAM word (RAM data width is fixed at 32)
//   lane_mask   : filled-lane count (1..4) -> byteenable mask
//   expand_mask : 4-bit lane mask -> 32-bit bit mask
package onchip_mem_loader_pkg;

  localparam int BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Only counts 1..4 occur when a word is written; 0 means "nothing filled".
  function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] count);
    logic [BYTES-1:0] m;
    case (count)
      3'd1:    m = 4'h1;
      3'd2:    m = 4'h3;
      3'd3:    m = 4'h7;
      3'd4:    m = 4'hF;
      default: m = 4'h0;
    endcase
    return m;
  endfunction

  function automatic logic [8*BYTES-1:0] expand_mask(input logic [BYTES-1:0] m);
    logic [8*BYTES-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) begin
      r[8*i +: 8] = {8{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/onchip_mem_loader_packer.sv
// Byte-to-word packer for the on-chip RAM loader.
// Bytes are placed little-endian: the first byte after a clear lands in lane 0.
//   clk, reset : clock and synchronous active-high reset
//   clear      : empty the buffer (lanes -> 0, count -> 0); wins over push
//   push       : byte_in is accepted into the next free lane
//   byte_in    : stream byte
//   word       : packed word, unfilled lanes read as 0
//   count      : number of filled lanes (0..4)
//   mask       : byteenable mask for the filled lanes
module onchip_mem_loader_packer
  import onchip_mem_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 push,
  input  logic [7:0]           byte_in,
  output logic [8*BYTES-1:0]   word,
  output logic [2:0]           count,
  output logic [BYTES-1:0]     mask
);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (push) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // One byte register per lane; a lane captures only when it is the next free one.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] byte_q, byte_d;

    always_comb begin
      byte_d = byte_q;
      if (clear) begin
        byte_d = '0;
      end else if (push && (count_q == 3'(gi))) begin
        byte_d = byte_in;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        byte_q <= '0;
      end else begin
        byte_q <= byte_d;
      end
    end

    assign word[8*gi +: 8] = byte_q;
  end

  assign count = count_q;
  assign mask  = lane_mask(count_q);

endmodule

// File: rtl/onchip_mem_loader.sv
// On-chip RAM loader: packs an 8-bit valid/ready stream into 32-bit words,
// writes them from a base word address, then reads every written word back
// and compares an additive checksum of the readback with the written sum.
//   clk, reset          : clock and synchronous active-high reset
//   start               : job request, honoured only in IDLE
//   base_addr, byte_len : job parameters, latched on start
//   s_data/s_valid/s_ready : byte stream
//   mem_*               : master side of the single-port RAM (1-cycle read latency)
//   busy                : job in progress (any state but IDLE)
//   done                : one-cycle completion pulse
//   checksum            : written-word sum, held until the next start
//   verify_err          : readback sum differed, held until the next start
module onchip_mem_loader
  import onchip_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_debugaccess,
  output logic              mem_clken,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              verify_err
);

  // Word count is ceil(byte_len/4), which needs one bit fewer than byte_len.
  localparam int WIDX_W = LEN_W - 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [WIDX_W-1:0] WIDX_ONE = WIDX_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    bytes_left_q, bytes_left_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [WIDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [31:0]         exp_sum_q, exp_sum_d;
  logic [31:0]         rd_sum_q, rd_sum_d;
  logic [31:0]         checksum_q, checksum_d;
  logic                verify_err_q, verify_err_d;
  logic                done_q, done_d;
  logic [3:0]          last_mask_q, last_mask_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_last_q, rd_last_d;
  logic                clken_q;

  logic                pk_clear;
  logic                pk_push;
  logic [31:0]         pk_word;
  logic [2:0]          pk_count;
  logic [3:0]          pk_mask;

  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WIDX_W-1:0]   last_idx;
  logic [31:0]         rd_word;

  onchip_mem_loader_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pk_clear),
    .push    (pk_push),
    .byte_in (s_data),
    .word    (pk_word),
    .count   (pk_count),
    .mask    (pk_mask)
  );

  // Word addresses wrap modulo 2^ADDR_W without any indication.
  assign wr_addr  = base_q + word_idx_q[ADDR_W-1:0];
  assign rd_addr  = base_q + rd_idx_q[ADDR_W-1:0];
  assign last_idx = word_idx_q - WIDX_ONE;

  // The final word may be partial; its unwritten lanes are masked out of the
  // readback so they match the zero lanes that went into the write sum.
  assign rd_word = mem_readdata & (rd_last_q ? expand_mask(last_mask_q) : 32'hFFFF_FFFF);

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    bytes_left_d   = bytes_left_q;
    word_idx_d     = word_idx_q;
    rd_idx_d       = rd_idx_q;
    exp_sum_d      = exp_sum_q;
    rd_sum_d       = rd_sum_q;
    checksum_d     = checksum_q;
    verify_err_d   = verify_err_q;
    done_d         = 1'b0;
    last_mask_d    = last_mask_q;
    rd_vld_d       = 1'b0;
    rd_last_d      = 1'b0;
    pk_clear       = 1'b0;
    pk_push        = 1'b0;
    s_ready        = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_debugaccess = 1'b0;
    mem_writedata  = '0;

    // Readback data returned one cycle after its address was issued.
    if (rd_vld_q) begin
      rd_sum_d = rd_sum_q + rd_word;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d       = base_addr;
          bytes_left_d = byte_len;
          word_idx_d   = '0;
          rd_idx_d     = '0;
          exp_sum_d    = '0;
          rd_sum_d     = '0;
          checksum_d   = '0;
          verify_err_d = 1'b0;
          pk_clear     = 1'b1;
          state_d      = (byte_len == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          pk_push      = 1'b1;
          bytes_left_d = bytes_left_q - LEN_ONE;
          // Lane 3 being filled now, or this is the very last byte.
          if ((pk_count == 3'd3) || (bytes_left_q == LEN_ONE)) begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        mem_chipselect  = 1'b1;
        mem_write       = 1'b1;
        mem_debugaccess = 1'b1;
        mem_address     = wr_addr;
        mem_byteenable  = pk_mask;
        mem_writedata   = pk_word;
        exp_sum_d       = exp_sum_q + pk_word;
        word_idx_d      = word_idx_q + WIDX_ONE;
        last_mask_d     = pk_mask;
        pk_clear        = 1'b1;
        if (bytes_left_q != '0) begin
          state_d = ST_LOAD;
        end else begin
          rd_idx_d = '0;
          state_d  = ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        mem_chipselect = 1'b1;
        mem_byteenable = 4'hF;
        mem_address    = rd_addr;
        rd_vld_d       = 1'b1;
        rd_last_d      = (rd_idx_q == last_idx);
        rd_idx_d       = rd_idx_q + WIDX_ONE;
        if (rd_idx_q == last_idx) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done_d       = 1'b1;
        checksum_d   = exp_sum_q;
        verify_err_d = (rd_sum_q != exp_sum_q);
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      bytes_left_q <= '0;
      word_idx_q   <= '0;
      rd_idx_q     <= '0;
      exp_sum_q    <= '0;
      rd_sum_q     <= '0;
      checksum_q   <= '0;
      verify_err_q <= 1'b0;
      done_q       <= 1'b0;
      last_mask_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      clken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      bytes_left_q <= bytes_left_d;
      word_idx_q   <= word_idx_d;
      rd_idx_q     <= rd_idx_d;
      exp_sum_q    <= exp_sum_d;
      rd_sum_q     <= rd_sum_d;
      checksum_q   <= checksum_d;
      verify_err_q <= verify_err_d;
      done_q       <= done_d;
      last_mask_q  <= last_mask_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      clken_q      <= 1'b1;
    end
  end

  assign mem_clken  = clken_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign checksum   = checksum_q;
  assign verify_err = verify_err_q;

endmodule

// File: tb/tb_onchip_mem_loader.sv
module tb_onchip_mem_loader;
  import onchip_mem_loader_pkg::*;

  localparam int ADDR_W = 15;
  localparam int LEN_W  = 17;
  localparam int NV     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  byte_len;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_debugaccess;
  logic              mem_clken;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata = '0;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;
  logic              verify_err;

  always #5 clk = ~clk;

  onchip_mem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .byte_len        (byte_len),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_chipselect  (mem_chipselect),
    .mem_write       (mem_write),
    .mem_debugaccess (mem_debugaccess),
    .mem_clken       (mem_clken),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .busy            (busy),
    .done            (done),
    .checksum        (checksum),
    .verify_err      (verify_err)
  );

  // ---------------- RAM model and bus monitor ----------------
  logic [31:0]       ram [0:32767];
  logic              req_rd = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  int                wr_cnt = 0;
  int                cs_cnt = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_log [256];
  logic [31:0]       wr_data_log [256];
  logic [3:0]        wr_be_log   [256];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = expand_mask(be);
    return (old_w & ~m) | (new_w & m);
  endfunction

  always @(negedge clk) begin
    req_rd   <= mem_chipselect && !mem_write;
    req_addr <= mem_address;
    if (mem_chipselect) cs_cnt <= cs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_chipselect && mem_write && mem_debugaccess) begin
      ram[mem_address]         <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      wr_addr_log[wr_cnt % 256] <= mem_address;
      wr_data_log[wr_cnt % 256] <= mem_writedata;
      wr_be_log[wr_cnt % 256]   <= mem_byteenable;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Read data appears for the whole cycle after the address cycle.
  always @(posedge clk) begin
    if (req_rd) begin
      mem_readdata <= ram[req_addr] ^ ((corrupt_en && (req_addr == corrupt_addr)) ? 32'h1 : 32'h0);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [7:0]        first;
    logic [7:0]        step;
    bit                gap;
    bit                midstart;
    bit                corrupt;
    logic [31:0]       exp_cks;
    bit                exp_err;
    logic [3:0]        last_be;
  } vec_t;

  vec_t vecs [NV];

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (4*k + i < int'(v.len)) w[8*i +: 8] = v.first + 8'(4*k + i) * v.step;
    end
    return w;
  endfunction

  task automatic run_vec(input int t);
    vec_t        v;
    int          sent, cyc, done_at, nwords, w0, c0, d0;
    bit          timeout, vld;
    logic [31:0] cks;
    logic        err;
    logic [3:0]  be;
    logic [ADDR_W-1:0] a;
    v = vecs[t];
    sent = 0; done_at = -1; timeout = 1'b1; cks = '0; err = 1'b0;
    corrupt_en   = v.corrupt;
    corrupt_addr = v.base + 15'd1;
    w0 = wr_cnt; c0 = cs_cnt; d0 = done_cnt;
    @(negedge clk);
    base_addr = v.base; byte_len = v.len; start = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 3000) begin
      if (cyc == 1) check($sformatf("busy[%0d]", t), 32'(busy), 32'd1);
      if (done) begin
        cks = checksum; err = verify_err; done_at = cyc; timeout = 1'b0;
        break;
      end
      start = v.midstart && (cyc == 3);
      if (start) begin
        base_addr = 15'h0300; byte_len = '0;
      end
      vld = (sent < int'(v.len)) && (!v.gap || (cyc % 2 == 0));
      s_valid = vld;
      s_data  = v.first + 8'(sent) * v.step;
      if (vld && s_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0;
    check($sformatf("idle_after_done[%0d]", t), 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    corrupt_en = 1'b0;
    nwords = (int'(v.len) + 3) / 4;
    check($sformatf("timeout[%0d]", t), 32'(timeout), 32'd0);
    check($sformatf("checksum[%0d]", t), cks, v.exp_cks);
    check($sformatf("verify_err[%0d]", t), 32'(err), 32'(v.exp_err));
    check($sformatf("done_pulses[%0d]", t), 32'(done_cnt - d0), 32'd1);
    check($sformatf("write_count[%0d]", t), 32'(wr_cnt - w0), 32'(nwords));
    check($sformatf("cs_cycles[%0d]", t), 32'(cs_cnt - c0), 32'(2 * nwords));
    if (v.len == '0) check($sformatf("done_latency[%0d]", t), 32'(done_at), 32'd2);
    for (int k = 0; k < nwords && (w0 + k) < wr_cnt; k++) begin
      be = (k == nwords - 1) ? v.last_be : 4'hF;
      a  = v.base + 15'(k);
      check($sformatf("wr_addr[%0d.%0d]", t, k), 32'(wr_addr_log[(w0 + k) % 256]), 32'(a));
      check($sformatf("wr_data[%0d.%0d]", t, k), wr_data_log[(w0 + k) % 256], exp_word(v, k));
      check($sformatf("wr_be[%0d.%0d]", t, k), 32'(wr_be_log[(w0 + k) % 256]), 32'(be));
      check($sformatf("ram_image[%0d.%0d]", t, k), ram[a] & expand_mask(be),
            exp_word(v, k) & expand_mask(be));
    end
    $display("job %0d base=0x%04h len=%0d checksum=0x%08h verify_err=%0d writes=%0d",
             t, v.base, v.len, cks, err, wr_cnt - w0);
  endtask

  initial begin
    int  sent, w0, c0;
    bit  found;

    //            base      len     first  step  gap  mid  cor  checksum        err  last_be
    vecs[0] = '{15'h0010, 17'd8,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0C0A0806, 1'b0, 4'hF};
    vecs[1] = '{15'h7FFF, 17'd5,  8'hAA, 8'h11, 1'b0, 1'b0, 1'b0, 32'hDDCCBC98, 1'b0, 4'h1};
    vecs[2] = '{15'h1234, 17'd0,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 4'h0};
    vecs[3] = '{15'h0100, 17'd8,  8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 32'h0C0A0806, 1'b1, 4'hF};
    vecs[4] = '{15'h0020, 17'd6,  8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 32'h40308060, 1'b0, 4'h3};
    vecs[5] = '{15'h0200, 17'd7,  8'hF0, 8'h01, 1'b0, 1'b0, 1'b0, 32'hF4E9E7E4, 1'b0, 4'h7};
    vecs[6] = '{15'h0005, 17'd1,  8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000005A, 1'b0, 4'h1};
    vecs[7] = '{15'h7FFE, 17'd12, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 32'h9693908C, 1'b0, 4'hF};

    reset = 1'b1; start = 1'b0; base_addr = '0; byte_len = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clken", 32'(mem_clken), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_chipselect", 32'(mem_chipselect), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_verify_err", 32'(verify_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("clken_after_reset", 32'(mem_clken), 32'd1);

    for (int t = 0; t < NV; t++) run_vec(t);

    // Reset while word 2 is being written.
    w0 = wr_cnt;
    @(negedge clk);
    base_addr = 15'h0400; byte_len = 17'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sent = 0; found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (mem_write && (mem_address == 15'h0402)) begin
        reset = 1'b1; found = 1'b1;
        break;
      end
      s_valid = (sent < 12);
      s_data  = 8'h31 + 8'(sent);
      if (s_valid && s_ready) sent++;
      @(negedge clk);
    end
    check("mid_reset_reached_word2", 32'(found), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    s_valid = 1'b1;
    check("mid_reset_chipselect", 32'(mem_chipselect), 32'd0);
    check("mid_reset_write", 32'(mem_write), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_s_ready", 32'(s_ready), 32'd0);
    check("mid_reset_clken", 32'(mem_clken), 32'd0);
    check("mid_reset_checksum", checksum, 32'd0);
    c0 = cs_cnt;
    repeat (20) @(negedge clk);
    s_valid = 1'b0;
    check("mid_reset_writes", 32'(wr_cnt - w0), 32'd3);
    check("mid_reset_no_bus", 32'(cs_cnt - c0), 32'd0);
    check("mid_reset_clken_back", 32'(mem_clken), 32'd1);
    $display("mid-job reset: writes before reset=%0d", wr_cnt - w0);

    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
